// File: rtl/alu_seg7_display.sv
// rtl/alu_seg7_display.sv - ALU result capture and 4-digit hex 7-segment display driver
//
// Captures the 16-bit ALU result plus carry/zero flags on a capture strobe and
// scans the held value across a common-anode 4-digit display, one digit per
// REFRESH_DIV clocks.
//
// Optional build macro: LZ_BLANK_EN (leading-zero blanking of digits 1..3).
//
// Ports:
//   clk       in   1   system clock
//   rst       in   1   asynchronous active-high reset
//   aluout    in  16   ALU result
//   cout      in   1   ALU carry-out
//   Zero      in   1   ALU zero flag
//   capture   in   1   1 = latch ALU outputs at this edge
//   captured  out  1   one-cycle pulse in the cycle after a capture
//   an        out  4   digit anodes, active-low, an[0] = rightmost
//   seg       out  7   segments gfedcba, active-low
//   dp        out  1   decimal point, active-low (lit on digit 3 when carry held)
//   led_cout  out  1   held carry flag
//   led_zero  out  1   held zero flag

module alu_seg7_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] aluout,
  input  logic        cout,
  input  logic        Zero,
  input  logic        capture,
  output logic        captured,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        led_cout,
  output logic        led_zero
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(REFRESH_DIV - 1);

  // Held ALU result and flags
  logic [15:0]   res_q,      res_d;
  logic          cout_q,     cout_d;
  logic          zero_q,     zero_d;
  logic          captured_q, captured_d;
  logic          led_cout_q, led_cout_d;
  logic          led_zero_q, led_zero_d;

  // Refresh scan state
  logic [CW-1:0] div_cnt_q,  div_cnt_d;
  logic [1:0]    digit_q,    digit_d;

  // Registered display outputs
  logic [3:0]    an_q,       an_d;
  logic [6:0]    seg_q,      seg_d;
  logic          dp_q,       dp_d;

  // Scan helpers
  logic          term_cnt;
  logic [1:0]    digit_next;
  logic [3:0]    nibble;
  logic          lz_blank;

  // Hex to active-low gfedcba.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Capture path. Flags to the LEDs come from the held copies, so they trail
  // the capture by one cycle.
  always_comb begin
    res_d      = res_q;
    cout_d     = cout_q;
    zero_d     = zero_q;
    captured_d = capture;
    led_cout_d = cout_q;
    led_zero_d = zero_q;
    if (capture) begin
      res_d  = aluout;
      cout_d = cout;
      zero_d = Zero;
    end
  end

  // The display registers are loaded with the digit being entered, and from
  // the pre-edge res_q, so a capture coinciding with the terminal count only
  // shows up from the following slot.
  always_comb begin
    term_cnt   = (div_cnt_q == DIV_LAST);
    digit_next = digit_q + 2'd1;
    nibble     = res_q[{digit_next, 2'b00} +: 4];

`ifdef LZ_BLANK_EN
    case (digit_next)
      2'd1:    lz_blank = (res_q[15:4]  == 12'd0);
      2'd2:    lz_blank = (res_q[15:8]  == 8'd0);
      2'd3:    lz_blank = (res_q[15:12] == 4'd0);
      default: lz_blank = 1'b0;
    endcase
`else
    lz_blank = 1'b0;
`endif

    div_cnt_d = term_cnt ? '0 : div_cnt_q + CW'(1);
    digit_d   = digit_q;
    an_d      = an_q;
    seg_d     = seg_q;
    dp_d      = dp_q;
    if (term_cnt) begin
      digit_d = digit_next;
      an_d    = ~(4'b0001 << digit_next);
      seg_d   = lz_blank ? 7'h7F : hex_to_seg(nibble);
      dp_d    = ~((digit_next == 2'd3) & cout_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q      <= 16'h0000;
      cout_q     <= 1'b0;
      zero_q     <= 1'b0;
      captured_q <= 1'b0;
      led_cout_q <= 1'b0;
      led_zero_q <= 1'b0;
      div_cnt_q  <= '0;
      digit_q    <= 2'd0;
      an_q       <= 4'b1111;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
    end else begin
      res_q      <= res_d;
      cout_q     <= cout_d;
      zero_q     <= zero_d;
      captured_q <= captured_d;
      led_cout_q <= led_cout_d;
      led_zero_q <= led_zero_d;
      div_cnt_q  <= div_cnt_d;
      digit_q    <= digit_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign captured = captured_q;
  assign an       = an_q;
  assign seg      = seg_q;
  assign dp       = dp_q;
  assign led_cout = led_cout_q;
  assign led_zero = led_zero_q;

endmodule
